// File: rtl/cnu_msg_expander.sv
// cnu_msg_expander: expands a compressed check-node record (min1, min2, argmin, signs) into per-edge C2V beats; CNU_EXP_OFFSET_EN enables offset min-sum
module cnu_msg_expander #(
   parameter int QUAN_SIZE = 3,
   parameter int CN_DEGREE = 10,
   parameter int IDX_WIDTH = 4,
   parameter int OFFSET    = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [QUAN_SIZE-1:0] in_m1,
   input  logic [QUAN_SIZE-1:0] in_m2,
   input  logic [IDX_WIDTH-1:0] in_min_idx,
   input  logic [CN_DEGREE-1:0] in_sign_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [QUAN_SIZE-1:0] out_mag,
   output logic                 out_sign,
   output logic [IDX_WIDTH-1:0] out_edge,
   output logic                 out_last,
   output logic                 idx_err
);
   typedef enum logic {IDLE, EMIT} state_t;
   state_t               state_q, state_d;
   logic [QUAN_SIZE-1:0] m1_q, m1_d, m2_q, m2_d, sel;
   logic [IDX_WIDTH-1:0] idx_q, idx_d, edge_q, edge_d;
   logic [CN_DEGREE-1:0] sv_q, sv_d;
   logic                 parity_q, parity_d, err_q, err_d, rst_hold_q;
   logic                 accept, fire;
   assign out_valid = state_q == EMIT;
   assign out_edge  = edge_q;
   assign out_last  = out_valid && edge_q == IDX_WIDTH'(CN_DEGREE - 1);
   assign in_ready  = (state_q == IDLE && !rst_hold_q) || (out_last && out_ready);
   assign accept    = in_valid && in_ready;
   assign fire      = out_valid && out_ready;
   // an out-of-range argmin never matches an edge, so every edge falls back to m1
   assign sel       = (edge_q == idx_q) ? m2_q : m1_q;
   assign out_sign  = parity_q ^ sv_q[edge_q];
   assign idx_err   = err_q;
`ifdef CNU_EXP_OFFSET_EN
   assign out_mag   = (sel > QUAN_SIZE'(OFFSET)) ? sel - QUAN_SIZE'(OFFSET) : '0;
`else
   assign out_mag   = sel;
`endif
   // next state: load a record on accept, otherwise step through the edges on each handshake
   always_comb begin
      state_d  = state_q;
      m1_d     = m1_q;
      m2_d     = m2_q;
      idx_d    = idx_q;
      sv_d     = sv_q;
      parity_d = parity_q;
      edge_d   = edge_q;
      err_d    = err_q;
      if (accept) begin
         m1_d     = in_m1;
         m2_d     = in_m2;
         idx_d    = in_min_idx;
         sv_d     = in_sign_vec;
         parity_d = ^in_sign_vec;
         edge_d   = '0;
         state_d  = EMIT;
         err_d    = err_q | ({1'b0, in_min_idx} >= (IDX_WIDTH + 1)'(CN_DEGREE));
      end else if (fire) begin
         state_d = out_last ? IDLE : EMIT;
         edge_d  = out_last ? edge_q : edge_q + 1'b1;
      end
   end
   // state and record registers; rst_hold_q keeps in_ready low for the cycle following reset
   always_ff @(posedge sys_clk) begin
      rst_hold_q <= sys_rst;
      if (sys_rst) begin
         state_q  <= IDLE;
         m1_q     <= '0;
         m2_q     <= '0;
         idx_q    <= '0;
         sv_q     <= '0;
         parity_q <= 1'b0;
         edge_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         m1_q     <= m1_d;
         m2_q     <= m2_d;
         idx_q    <= idx_d;
         sv_q     <= sv_d;
         parity_q <= parity_d;
         edge_q   <= edge_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_cnu_msg_expander.sv
// tb_cnu_msg_expander: scoreboard bench for cnu_msg_expander with directed records
module tb_cnu_msg_expander;
   logic       sys_clk = 1'b0, sys_rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [2:0] in_m1 = '0, in_m2 = '0;
   logic [3:0] in_min_idx = '0;
   logic [9:0] in_sign_vec = '0;
   logic       in_ready, out_valid, out_sign, out_last, idx_err;
   logic [2:0] out_mag;
   logic [3:0] out_edge;

   typedef struct packed {logic [3:0] e; logic [2:0] m; logic s; logic l;} beat_t;
   beat_t q[$];
   int    n_cmp = 0, n_bad = 0, hs = 0, pcyc = 0, acc_cyc = 0;
   logic  last_at_acc = 1'b0;

   cnu_msg_expander dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_m1(in_m1), .in_m2(in_m2), .in_min_idx(in_min_idx), .in_sign_vec(in_sign_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag), .out_sign(out_sign),
      .out_edge(out_edge), .out_last(out_last), .idx_err(idx_err)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) pcyc++;

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [2:0] off(input logic [2:0] m);
`ifdef CNU_EXP_OFFSET_EN
      return (m > 3'd1) ? m - 3'd1 : 3'd0;
`else
      return m;
`endif
   endfunction

   // monitor: every presented beat must match the scoreboard head; pop on handshake
   always @(negedge sys_clk) begin
      if (out_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got edge %0d expected no beat", out_edge);
         end else begin
            cmp($sformatf("edge_e%0d", q[0].e), int'(out_edge), int'(q[0].e));
            cmp($sformatf("mag_e%0d", q[0].e), int'(out_mag), int'(q[0].m));
            cmp($sformatf("sign_e%0d", q[0].e), int'(out_sign), int'(q[0].s));
            cmp($sformatf("last_e%0d", q[0].e), int'(out_last), int'(q[0].l));
            if (out_ready) begin
               void'(q.pop_front());
               hs++;
            end
         end
      end
   end

   // arg: edge expected to carry m2 (15 = none); sg: hand-computed output sign per edge
   task automatic send(input logic [2:0] m1, input logic [2:0] m2, input logic [3:0] idx,
                       input logic [9:0] sv, input int arg, input logic [9:0] sg, input bit hold);
      bit    ok = 1'b0;
      beat_t b;
      in_valid = 1'b1; in_m1 = m1; in_m2 = m2; in_min_idx = idx; in_sign_vec = sv;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge sys_clk);
         if (in_ready) begin
            ok = 1'b1;
            acc_cyc = pcyc;
            last_at_acc = out_last;
            for (int k = 0; k < 10; k++) begin
               b.e = 4'(k);
               b.m = (k == arg) ? off(m2) : off(m1);
               b.s = sg[k];
               b.l = (k == 9);
               q.push_back(b);
            end
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got no accept expected accept");
      end
      @(posedge sys_clk); #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300; i++) begin
         if (q.size() == 0) break;
         @(posedge sys_clk); #1;
      end
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      int a, h0;
      repeat (2) @(posedge sys_clk);
      #1;
      cmp("rst_in_ready", int'(in_ready), 0);
      sys_rst = 1'b0;
      cmp("rst_out_valid", int'(out_valid), 0);
      cmp("rst_out_mag", int'(out_mag), 0);
      cmp("rst_out_sign", int'(out_sign), 0);
      cmp("rst_out_edge", int'(out_edge), 0);
      cmp("rst_out_last", int'(out_last), 0);
      cmp("rst_idx_err", int'(idx_err), 0);
      @(posedge sys_clk); #1;
      cmp("post_rst_in_ready", int'(in_ready), 1);

      // basic expansion, parity 0
      send(3'd1, 3'd4, 4'd3, 10'b0000000101, 3, 10'b0000000101, 1'b0);
      wait_drain();
      @(posedge sys_clk); #1;
      cmp("idle_out_valid", int'(out_valid), 0);
      cmp("idle_in_ready", int'(in_ready), 1);

      // backpressure 1,0,0 pattern
      h0 = hs;
      send(3'd1, 3'd4, 4'd3, 10'b0000000101, 3, 10'b0000000101, 1'b0);
      for (int i = 0; i < 60; i++) begin
         out_ready = (i % 3 == 0);
         if (q.size() == 0) break;
         @(posedge sys_clk); #1;
      end
      out_ready = 1'b1;
      wait_drain();
      cmp("bp_handshakes", hs - h0, 10);

      // back-to-back: A parity 1, B parity 0
      send(3'd2, 3'd6, 4'd0, 10'b0000000111, 0, 10'b1111111000, 1'b1);
      a = acc_cyc;
      send(3'd3, 3'd7, 4'd9, 10'b1000000001, 9, 10'b1000000001, 1'b0);
      cmp("b2b_accept_gap", acc_cyc - a, 10);
      cmp("b2b_accept_on_last", int'(last_at_acc), 1);
      wait_drain();
      cmp("b2b_total_cycles", pcyc - a, 21);

      // out-of-range argmin
      cmp("idx_err_before", int'(idx_err), 0);
      send(3'd2, 3'd5, 4'd12, 10'b0000010000, 15, 10'b1111101111, 1'b0);
      cmp("idx_err_next", int'(idx_err), 1);
      wait_drain();
      cmp("idx_err_sticky", int'(idx_err), 1);

      // saturation record (offset build: edge0 2, rest 0)
      send(3'd0, 3'd3, 4'd0, 10'b1111111111, 0, 10'b1111111111, 1'b0);
      wait_drain();

      // reset during edge 4
      send(3'd1, 3'd4, 4'd3, 10'b0000000101, 3, 10'b0000000101, 1'b0);
      repeat (4) begin
         @(posedge sys_clk); #1;
      end
      cmp("rst_mid_edge", int'(out_edge), 4);
      sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      q.delete();
      cmp("rst_mid_out_valid", int'(out_valid), 0);
      cmp("rst_mid_idx_err", int'(idx_err), 0);
      cmp("rst_mid_in_ready", int'(in_ready), 0);
      sys_rst = 1'b0;
      @(posedge sys_clk); #1;
      cmp("rst_after_in_ready", int'(in_ready), 1);
      cmp("rst_after_out_valid", int'(out_valid), 0);
      repeat (12) @(posedge sys_clk);
      #1;
      cmp("rst_no_beats", int'(out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cnu_msg_expander.md
Name: cnu_msg_expander

Overview:
- Expands one compressed check-node result into per-edge check-to-variable (C2V) messages, one edge per beat.
- Compressed input: min1, min2, argmin index, per-edge sign vector.
- Sits between the CNU min-finder tree (CNU10 class) and the layer decoder's variable-node message write-back path.
- Output per edge: magnitude and sign, selected by whether the edge is the argmin edge.

Parameters:
QUAN_SIZE, 3, magnitude width in bits
CN_DEGREE, 10, number of edges per check node (beats per expansion)
IDX_WIDTH, 4, width of edge index; must satisfy 2^IDX_WIDTH >= CN_DEGREE
OFFSET, 1, offset subtracted from magnitudes when CNU_EXP_OFFSET_EN is defined

Ports:
sys_clk      input   1            system clock, all logic on rising edge
sys_rst      input   1            synchronous active-high reset
in_valid     input   1            compressed record valid
in_ready     output  1            expander can accept a record
in_m1        input   QUAN_SIZE    smallest incoming V2C magnitude
in_m2        input   QUAN_SIZE    second-smallest incoming V2C magnitude
in_min_idx   input   IDX_WIDTH    edge index of in_m1
in_sign_vec  input   CN_DEGREE    sign bit of each incoming V2C message, bit k = edge k
out_valid    output  1            C2V beat valid
out_ready    input   1            downstream accepts beat
out_mag      output  QUAN_SIZE    C2V magnitude for edge out_edge
out_sign     output  1            C2V sign for edge out_edge
out_edge     output  IDX_WIDTH    edge index of current beat, 0..CN_DEGREE-1
out_last     output  1            high on beat with out_edge == CN_DEGREE-1
idx_err      output  1            sticky: an accepted record had in_min_idx >= CN_DEGREE

Behaviour:
- Reset: state IDLE; in_ready=0 during reset cycle and 1 after; out_valid=0, out_mag=0, out_sign=0, out_edge=0, out_last=0, idx_err=0; all record registers cleared.
- Reset mid-expansion aborts the record; no further beats of it are emitted.
- Two-state FSM, IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, register m1, m2, min_idx, sign_vec.
  - Compute parity = XOR of all CN_DEGREE sign bits, registered.
  - Set edge counter to 0 and go to EMIT.
- EMIT:
  - out_valid=1; out_edge = edge counter.
  - out_mag = (edge == min_idx) ? m2 : m1.
  - out_sign = parity XOR sign_vec[edge].
  - out_last = (edge == CN_DEGREE-1).
  - Outputs are registered/stable while out_valid && !out_ready; no beat dropped or repeated.
  - On out_valid&&out_ready: if not last, increment counter; if last, return to IDLE.
- Back-to-back records:
  - in_ready is also 1 in EMIT when out_last && out_ready (combinational from out_ready).
  - A record accepted that cycle moves the FSM directly to EMIT, edge 0, next cycle, with no bubble.
  - Otherwise in_ready=0 in EMIT.
- First beat latency: 1 cycle after accept. Throughput: CN_DEGREE beats per record at full out_ready.
- Out-of-range index:
  - in_min_idx >= CN_DEGREE: every edge gets m1.
  - idx_err is set the cycle after accept and stays set until sys_rst.
- Ties (m1 == m2): no special case; the argmin edge gets m2, which equals m1.
- Widths: magnitudes unsigned QUAN_SIZE bits; no arithmetic growth.

Optional Feature:
- Macro CNU_EXP_OFFSET_EN.
- Defined: out_mag = max(selected magnitude - OFFSET, 0), saturating at 0 (offset min-sum); computed combinationally from registered selection, latency unchanged.
- Undefined: out_mag = selected magnitude unmodified (plain min-sum); the OFFSET parameter is ignored.

Test Plan:
- Basic expansion:
  - Stimulus: m1=1, m2=4, min_idx=3, sign_vec=10'b00_0000_0101, out_ready=1.
  - Response: 10 beats; edge3 mag=4, all others mag=1; parity=0, so out_sign[k]=sign_vec[k]; out_last on edge 9 only.
- Backpressure:
  - Stimulus: same record, out_ready toggled 1,0,0,1,...
  - Response: out_edge/out_mag/out_sign held while stalled; exactly 10 handshakes with edges 0..9 in order.
- Back-to-back records:
  - Stimulus: two records with in_valid held high, out_ready=1.
  - Response: second record accepted on the last beat of the first; 20 consecutive valid beats, no gap; second record's edge 0 follows immediately.
- Index error:
  - Stimulus: min_idx=12, m1=2, m2=5.
  - Response: all 10 beats mag=2; idx_err=1 from next cycle onward, cleared only by sys_rst.
- Reset mid-record:
  - Stimulus: assert sys_rst during edge 4.
  - Response: next cycle out_valid=0, idx_err=0, in_ready=0; cycle after deassert in_ready=1 and no remaining beats emitted.
- Offset (CNU_EXP_OFFSET_EN defined, OFFSET=1):
  - Stimulus: m1=0, m2=3, min_idx=0.
  - Response: edge0 mag=2, edges 1..9 mag=0 (saturated).
